// File: rtl/alu_exec_unit.sv
// MIPS ALU control plus execute stage: decodes ALUopcode/funct and runs the op behind
// valid/ready handshakes. Single-cycle ops finish in one edge; mul is radix-2 shift-add.
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUopcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       ALUOperation,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1001;
  localparam logic [3:0] OpSra = 4'b1010;
  localparam logic [3:0] OpMul = 4'b1100;
  localparam logic [3:0] OpIll = 4'b1111;

  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;

  logic [3:0]       dec_op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   shamt;
  logic             accept;

  assign shamt    = b[SHW-1:0];
  assign in_ready = !reset && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    dec_op = OpIll;
    unique case (ALUopcode)
      2'd0: dec_op = OpAdd;
      2'd1: dec_op = OpSub;
      2'd3: dec_op = OpSlt;
      default: begin
        case (funct)
          6'd1, 6'd32:  dec_op = OpAdd;
          6'd34:        dec_op = OpSub;
          6'd36, 6'd44: dec_op = OpAnd;
          6'd37, 6'd45: dec_op = OpOr;
          6'd7, 6'd42:  dec_op = OpSlt;
          6'd0:         dec_op = OpSll;
          6'd2:         dec_op = OpSrl;
          6'd3:         dec_op = OpSra;
          6'd24:        dec_op = MUL_EN ? OpMul : OpIll;
          default:      dec_op = OpIll;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSll:   alu_res = a << shamt;
      OpSrl:   alu_res = a >> shamt;
      OpSra:   alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 4'b0000;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      // Drain first; a completion in the same edge overrides below.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q  <= dec_op;
            err_q <= (dec_op == OpIll);
            if (dec_op == OpMul) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              result_q    <= alu_res;
              out_valid_q <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (cnt_q == CntLast) begin
            result_q    <= acc_next;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ALUOperation = op_q;
  assign result       = result_q;
  assign zero         = (result_q == '0);
  assign err          = err_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised self-checking bench for alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUopcode;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        in_valid, out_ready;
  logic        in_ready, zero, err, out_valid;
  logic [3:0]  ALUOperation;
  logic [31:0] result;
  // Second instance with the multiplier disabled shares the inputs.
  logic        in_ready2, zero2, err2, out_valid2;
  logic [3:0]  ALUOperation2;
  logic [31:0] result2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ALUopcode(ALUopcode), .funct(funct), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .ALUOperation(ALUOperation), .result(result),
    .zero(zero), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .reset(reset), .ALUopcode(ALUopcode), .funct(funct), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready2), .ALUOperation(ALUOperation2), .result(result2),
    .zero(zero2), .err(err2), .out_valid(out_valid2), .out_ready(out_ready)
  );

  // Reference: what the instruction means, computed with plain arithmetic.
  function automatic void model(input logic [1:0] opc, input logic [5:0] f,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [3:0] code, output logic [31:0] r,
                                output logic e);
    int unsigned sh;
    logic [63:0] p;
    sh = y % 32;
    p  = {32'b0, x} * {32'b0, y};
    e  = 1'b0;
    if (opc == 2'd0 || (opc == 2'd2 && (f == 1 || f == 32))) begin
      code = 4'b0010; r = x + y;
    end else if (opc == 2'd1 || (opc == 2'd2 && f == 34)) begin
      code = 4'b0110; r = x - y;
    end else if (opc == 2'd3 || (opc == 2'd2 && (f == 7 || f == 42))) begin
      code = 4'b0111; r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    end else if (f == 36 || f == 44) begin
      code = 4'b0000; r = x & y;
    end else if (f == 37 || f == 45) begin
      code = 4'b0001; r = x | y;
    end else if (f == 0) begin
      code = 4'b1000; r = x << sh;
    end else if (f == 2) begin
      code = 4'b1001; r = x >> sh;
    end else if (f == 3) begin
      code = 4'b1010; r = 32'($signed(x) >>> sh);
    end else if (f == 24) begin
      code = 4'b1100; r = p[31:0];
    end else begin
      code = 4'b1111; r = 32'd0; e = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    ALUopcode = 2'd0; funct = 6'd32; a = 32'd9; b = 32'd9;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready0: got %b want 0", in_ready); else passed++;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (result !== 32'd0) $display("FAIL reset_result: got %h want 0", result); else passed++;
    total++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (ALUOperation !== 4'b0000) $display("FAIL reset_aluop: got %b want 0000", ALUOperation); else passed++;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  fs [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] rv [3];
    logic [3:0]  ov [3];
    fs[0] = 6'd34; av[0] = 32'd5;          bv[0] = 32'd7; rv[0] = 32'hFFFF_FFFE; ov[0] = 4'b0110;
    fs[1] = 6'd42; av[1] = 32'hFFFF_FFFF;  bv[1] = 32'd1; rv[1] = 32'd1;         ov[1] = 4'b0111;
    fs[2] = 6'd3;  av[2] = 32'h8000_0000;  bv[2] = 32'd4; rv[2] = 32'hF800_0000; ov[2] = 4'b1010;
    out_ready = 1'b1; in_valid = 1'b1; ALUopcode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      funct = fs[i]; a = av[i]; b = bv[i];
      #0;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (result !== rv[i]) $display("FAIL b2b_result[%0d]: got %h want %h", i, result, rv[i]); else passed++;
      total++; if (ALUOperation !== ov[i]) $display("FAIL b2b_aluop[%0d]: got %b want %b", i, ALUOperation, ov[i]); else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_random();
    int fl [14];
    logic [3:0]  ec;
    logic [31:0] er;
    logic        ee;
    fl = '{0, 1, 2, 3, 7, 32, 34, 36, 37, 42, 44, 45, 63, 17};
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'b1;
      ALUopcode = 2'($urandom_range(0, 3));
      funct     = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(fl[$urandom_range(0, 13)]);
      if (funct == 6'd24) funct = 6'd63;
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h3F;
      model(ALUopcode, funct, a, b, ec, er, ee);
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL rnd_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (result !== er) $display("FAIL rnd_result[%0d] op%0d f%0d a=%h b=%h: got %h want %h", i, ALUopcode, funct, a, b, result, er); else passed++;
      total++; if (ALUOperation !== ec) $display("FAIL rnd_aluop[%0d]: got %b want %b", i, ALUOperation, ec); else passed++;
      total++; if (err !== ee) $display("FAIL rnd_err[%0d]: got %b want %b", i, err, ee); else passed++;
      total++; if (zero !== (er == 32'd0)) $display("FAIL rnd_zero[%0d]: got %b want %b", i, zero, (er == 32'd0)); else passed++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    in_valid = 1'b1; ALUopcode = 2'd2; funct = 6'd24; a = x; b = y; out_ready = 1'b1;
    #0;
    total++; if (in_ready !== 1'b1) $display("FAIL mul_ready_pre: got %b want 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      // Inputs wander during the multiply and must be ignored.
      a = $urandom; b = $urandom; funct = 6'($urandom);
      total++; if ({in_ready, out_valid} !== 2'b00) $display("FAIL mul_busy[%0d]: got %b want 00", k, {in_ready, out_valid}); else passed++;
      if (k < 31) tick();
    end
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL mul_valid: got %b want 1", out_valid); else passed++;
    total++; if (result !== p[31:0]) $display("FAIL mul_result %h*%h: got %h want %h", x, y, result, p[31:0]); else passed++;
    total++; if (ALUOperation !== 4'b1100) $display("FAIL mul_aluop: got %b want 1100", ALUOperation); else passed++;
    total++; if (err !== 1'b0) $display("FAIL mul_err: got %b want 0", err); else passed++;
    tick();
    total++; if ({in_ready, out_valid} !== 2'b01) $display("FAIL mul_hold: got %b want 01", {in_ready, out_valid}); else passed++;
    total++; if (result !== p[31:0]) $display("FAIL mul_hold_result: got %h want %h", result, p[31:0]); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL mul_release: got %b want 10", {in_ready, out_valid}); else passed++;
  endtask

  task automatic test_mul();
    do_mul(32'h0001_0003, 32'h0002_0005);
    total++; if (result !== 32'h000B_000F) $display("FAIL mul_spec1: got %h want 000b000f", result); else passed++;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (result !== 32'h0000_0001) $display("FAIL mul_spec2: got %h want 00000001", result); else passed++;
    for (int i = 0; i < 4; i++) do_mul($urandom, $urandom);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; ALUopcode = 2'd0; a = 32'd1; b = 32'd2;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a = $urandom; b = $urandom;
      total++; if (result !== 32'd3) $display("FAIL bp_result[%0d]: got %h want 3", k, result); else passed++;
      total++; if ({in_ready, out_valid} !== 2'b01) $display("FAIL bp_hs[%0d]: got %b want 01", k, {in_ready, out_valid}); else passed++;
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd10; b = 32'd20;
    #0;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready: got %b want 1", in_ready); else passed++;
    tick();
    total++; if (result !== 32'd30) $display("FAIL bp_new_result: got %h want 1e", result); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_new_valid: got %b want 1", out_valid); else passed++;
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; ALUopcode = 2'd2; funct = 6'd63; a = 32'd7; b = 32'd9;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL ill_valid: got %b want 1", out_valid); else passed++;
    total++; if (result !== 32'd0) $display("FAIL ill_result: got %h want 0", result); else passed++;
    total++; if (err !== 1'b1) $display("FAIL ill_err: got %b want 1", err); else passed++;
    total++; if (zero !== 1'b1) $display("FAIL ill_zero: got %b want 1", zero); else passed++;
    total++; if (ALUOperation !== 4'b1111) $display("FAIL ill_aluop: got %b want 1111", ALUOperation); else passed++;
    funct = 6'd24;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid2 !== 1'b1) $display("FAIL nomul_valid: got %b want 1", out_valid2); else passed++;
    total++; if (result2 !== 32'd0) $display("FAIL nomul_result: got %h want 0", result2); else passed++;
    total++; if (err2 !== 1'b1) $display("FAIL nomul_err: got %b want 1", err2); else passed++;
    total++; if (zero2 !== 1'b1) $display("FAIL nomul_zero: got %b want 1", zero2); else passed++;
    total++; if (ALUOperation2 !== 4'b1111) $display("FAIL nomul_aluop: got %b want 1111", ALUOperation2); else passed++;
    // Main instance took that as a real multiply; let it finish and drain.
    repeat (34) tick();
    total++; if (in_ready !== 1'b1) $display("FAIL ill_mul_settle: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1; in_valid = 1'b1; ALUopcode = 2'd2; funct = 6'd24;
    a = 32'h1234_5678; b = 32'h9ABC_DEF1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rmm_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL rmm_ready: got %b want 0", in_ready); else passed++;
    total++; if (result !== 32'd0) $display("FAIL rmm_result: got %h want 0", result); else passed++;
    reset = 1'b0; in_valid = 1'b1; ALUopcode = 2'd0; a = 32'd4; b = 32'd4;
    #0;
    total++; if (in_ready !== 1'b1) $display("FAIL rmm_ready_after: got %b want 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (result !== 32'd8) $display("FAIL rmm_add_result: got %h want 8", result); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL rmm_add_valid: got %b want 1", out_valid); else passed++;
    total++; if (ALUOperation !== 4'b0010) $display("FAIL rmm_add_aluop: got %b want 0010", ALUOperation); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rmm_add_err: got %b want 0", err); else passed++;
    tick();
    do_mul(32'd3, 32'd5);
    total++; if (result !== 32'd15) $display("FAIL rmm_mul_after: got %h want f", result); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised ALU control-and-execute stage for the MIPS datapath. Decodes the 2-bit ALU opcode from the main control and the R-type `funct` field into an extended 4-bit ALU operation. Executes that operation on two WIDTH-bit operands behind valid/ready handshakes. Single-cycle ops (add, sub, and, or, slt, shifts) complete in one cycle; multiply is iterative and multi-cycle. The block sits between the register-read stage and writeback, replacing the combinational ALU control plus ALU pair.

## Interface
- `WIDTH`, 32: operand/result width; must be a power of two, ≥8.
- `MUL_EN`, 1: 1 enables the iterative multiplier; 0 decodes funct 24 as illegal.
- `SHW`, $clog2(WIDTH): derived shift-amount width; do not override.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ALUopcode`  in  2  main-control ALU opcode.
- `funct`  in  6  R-type function field.
- `a`, `b`  in  WIDTH  operands; for shifts the value is `a` and the amount is `b[SHW-1:0]`.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept this cycle.
- `ALUOperation`  out  4  registered decoded op of the last accepted request.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`.
- `err`  out  1  last result came from an illegal decode.
- `out_valid`  out  1  result/zero/err valid.
- `out_ready`  in  1  consumer takes result.

## Operation
- **Decode:**
  - `ALUopcode` 0 → add 0010; 1 → sub 0110; 3 → slt 0111 (signed).
  - `ALUopcode` 2 decodes `funct`:
    - 1 or 32 → add 0010
    - 34 → sub 0110
    - 36/44 → and 0000
    - 37/45 → or 0001
    - 7/42 → slt 0111
    - 0 → sll 1000
    - 2 → srl 1001
    - 3 → sra 1010
    - 24 → mul 1100 (MUL_EN=1 only)
    - anything else → illegal 1111
- **Arithmetic:**
  - Add/sub are modulo 2^WIDTH; no overflow flag.
  - slt yields 1 if signed `a < b`, else 0.
  - Shifts use `b[SHW-1:0]`; sra replicates `a[WIDTH-1]`.
  - mul yields the low WIDTH bits of `a*b` (identical signed or unsigned).
  - Illegal ops: result 0, `err` 1. All legal ops: `err` 0.
- **Handshake:**
  - A transfer occurs when `in_valid && in_ready`.
  - `in_ready = !reset && state==IDLE && (!out_valid || out_ready)`.
  - Output is held stable while `out_valid && !out_ready`.
  - `out_valid` clears on `out_ready` unless a new result loads in the same edge.
- **FSM:**
  - IDLE: accept a single-cycle op → register result, `out_valid`=1, stay IDLE. Accept mul → load multiplicand, multiplier and accumulator, counter=0, go MUL.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, counter+1. When counter reaches WIDTH-1, the final iteration writes `result` and sets `out_valid`; go HOLD.
  - HOLD: wait for `out_ready`, then go IDLE. `in_ready` is 0 in HOLD, so no back-to-back mul issue.
- `ALUOperation` and `err` are updated on acceptance; `result`/`zero` are updated at completion.

## Timing
- **Reset:** synchronous, highest priority. After it: state IDLE; `result`=0; `zero`=1; `err`=0; `out_valid`=0; `ALUOperation`=0000; counter=0. `in_ready`=0 while `reset` is high.
- **Single-cycle latency:** accepted at edge T → `out_valid` high after edge T.
- **Throughput:** 1 op/cycle when `out_ready` is held high. A simultaneous drain and accept in one edge is legal, and the new result replaces the old one.
- **Mul latency:** accepted at edge T → `out_valid` high after edge T+WIDTH. `in_ready` is low from T until the edge after `out_ready` in HOLD.
- **Reset mid-mul:** aborts the operation, discards partial product, `out_valid`=0 next cycle.
- **Input validity:** `funct`/`a`/`b` are only sampled on an accepting edge. Changes at other times have no effect, including changes during MUL.
- **Counter:** width is SHW bits, and the transition out of MUL fires at counter == WIDTH-1.

## Test plan
- **Reset:** hold `reset` 2 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `result`=0, `zero`=1, `ALUOperation`=0000.
- **Back-to-back single-cycle ops:** `out_ready`=1, issue op2/f34 a=5 b=7, then op2/f42 a=0xFFFFFFFF b=1, then op2/f3 a=0x80000000 b=4 on consecutive cycles → results 0xFFFFFFFE, 1, 0xF8000000 on consecutive cycles. `ALUOperation` 0110, 0111, 1010.
- **Multiply (WIDTH=32):** op2/f24 a=0x0001_0003 b=0x0002_0005 → `result`=0x000B_000F exactly 32 cycles after accept. `in_ready`=0 throughout. a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000001.
- **Backpressure:** `out_ready`=0, add a=1 b=2 → `result`=3 held and `in_ready`=0 for 5 cycles. Raise `out_ready` with `in_valid` → new op accepted in the same edge.
- **Illegal decode:** op2/f63 → `result`=0, `err`=1, `zero`=1, `ALUOperation`=1111, latency 1. With MUL_EN=0, f24 gives the same response.
- **Reset mid-multiply:** assert `reset` 10 cycles into a mul → next cycle `out_valid`=0. After deassert, an add a=4 b=4 completes with `result`=8 and no residue from the aborted mul.
